// File: rtl/usr_shift_sequencer_if.sv
// Command and register-side signal bundle for usr_shift_sequencer.
// master = sequencer side, slave = command source / shift register side.
interface usr_shift_sequencer_if #(
    parameter int N     = 4,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [N-1:0]     cmd_data;
    logic [N-1:0]     q_in;
    logic [1:0]       s;
    logic [N-1:0]     I;
    logic             MSB_in;
    logic             LSB_in;
    logic             busy;
    logic             done;

    modport master (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, q_in,
        output cmd_ready, s, I, MSB_in, LSB_in, busy, done
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_count, cmd_data, q_in,
        input  cmd_ready, s, I, MSB_in, LSB_in, busy, done
    );
endinterface

// File: rtl/usr_shift_sequencer.sv
// Sequencer that plays LOAD / SHR / SHL / ROR commands onto the mode and
// serial lines of a universal shift register, one handshake per command.
module usr_shift_sequencer #(
    parameter int N     = 4,
    parameter int CNT_W = 4
) (
    input logic                   clk,
    input logic                   reset,
    usr_shift_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_SHR = 2'b01, OP_SHL = 2'b10, OP_ROR = 2'b11} op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, k_q, k_d;
    logic [N-1:0]     data_q, data_d, I_q, I_d;
    logic [N-1:0]     sr_bits, sl_bits;
    logic [1:0]       s_q, s_d;
    logic             msb_q, msb_d, lsb_q, lsb_d;
    logic             busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic             accept;

    assign accept = bus.cmd_valid && ready_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = op_t'(bus.cmd_op);
                    cnt_d  = bus.cmd_count;
                    data_d = bus.cmd_data;
                    k_d    = '0;
                    if (op_d == OP_LOAD)
                        state_d = LOAD;
                    else if (cnt_d != '0)
                        state_d = SHIFT;
                    else
                        state_d = DONE;
                end
            end
            LOAD:  state_d = DONE;
            SHIFT: begin
                if (k_q == cnt_q - CNT_W'(1))
                    state_d = DONE;
                else
                    k_d = k_q + CNT_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    // Shifting the captured word by k yields 0 once k reaches N.
    always_comb begin
        sr_bits = data_d >> k_d;
        sl_bits = data_d << k_d;
        s_d     = 2'b00;
        I_d     = I_q;
        msb_d   = 1'b0;
        lsb_d   = 1'b0;
        case (state_d)
            LOAD: begin
                s_d = 2'b11;
                I_d = data_d;
            end
            SHIFT: begin
                case (op_d)
                    OP_SHR: begin
                        s_d   = 2'b01;
                        msb_d = sr_bits[0];
                    end
                    OP_SHL: begin
                        s_d   = 2'b10;
                        lsb_d = sl_bits[N-1];
                    end
                    OP_ROR:  s_d = 2'b01;
                    default: s_d = 2'b00;
                endcase
            end
            default: s_d = 2'b00;
        endcase
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            cnt_q   <= '0;
            k_q     <= '0;
            data_q  <= '0;
            I_q     <= '0;
            s_q     <= 2'b00;
            msb_q   <= 1'b0;
            lsb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            data_q  <= data_d;
            I_q     <= I_d;
            s_q     <= s_d;
            msb_q   <= msb_d;
            lsb_q   <= lsb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.s         = s_q;
    assign bus.I         = I_q;
    assign bus.LSB_in    = lsb_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    // Rotate feedback must see the register's current bit 0, so it bypasses the output flop.
    assign bus.MSB_in    = (state_q == SHIFT && op_q == OP_ROR) ? bus.q_in[0] : msb_q;
endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Self-checking bench: drives commands, models the downstream 4-bit shift
// register, and checks every cycle against expected traces built from the command rules.
module tb_usr_shift_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [3:0] env_q  = 4'b0000;
    logic [3:0] last_I = 4'b0000;

    usr_shift_sequencer_if #(.N(4), .CNT_W(4)) bus ();

    usr_shift_sequencer #(.N(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Downstream universal shift register fed by the sequencer.
    always @(posedge clk) begin
        case (bus.s)
            2'b01:   env_q <= {bus.MSB_in, env_q[3:1]};
            2'b10:   env_q <= {env_q[2:0], bus.LSB_in};
            2'b11:   env_q <= bus.I;
            default: env_q <= env_q;
        endcase
    end

    assign bus.q_in = env_q;

    task automatic test_reset();
        logic [10:0] obs;
        reset         = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_count = 4'd3;
        bus.cmd_data  = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            obs = {bus.s, bus.I, bus.MSB_in, bus.LSB_in, bus.busy, bus.done, bus.cmd_ready};
            n_checks++;
            if (obs !== 11'b0) $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, obs, 11'b0);
            else n_pass++;
        end
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        last_I        = 4'b0000;
        @(negedge clk);
        obs = {bus.s, bus.I, bus.MSB_in, bus.LSB_in, bus.busy, bus.done, bus.cmd_ready};
        n_checks++;
        if (obs !== 11'b00_0000_00001) $display("FAIL reset_release: got %b expected %b", obs, 11'b00_0000_00001);
        else n_pass++;
    endtask

    task automatic run_cmd(input logic [1:0] op, input int cnt, input logic [3:0] data, input bit churn);
        logic [14:0] obs, exp;
        logic [3:0]  qe;
        logic [1:0]  es;
        logic        b_msb, b_lsb;
        int          len;
        int          waited;
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL ready_wait: got %b expected 1", bus.cmd_ready);
        else n_pass++;
        qe            = env_q;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_count = 4'(cnt);
        bus.cmd_data  = data;
        @(negedge clk);
        if (!churn) bus.cmd_valid = 1'b0;
        len = (op == 2'b00) ? 1 : cnt;
        for (int c = 0; c < len; c++) begin
            b_msb = 1'b0;
            b_lsb = 1'b0;
            case (op)
                2'b00: begin es = 2'b11; last_I = data; end
                2'b01: begin es = 2'b01; b_msb = (c < 4) ? data[c] : 1'b0; end
                2'b10: begin es = 2'b10; b_lsb = (c < 4) ? data[3-c] : 1'b0; end
                default: begin es = 2'b01; b_msb = qe[0]; end
            endcase
            exp = {qe, es, last_I, b_msb, b_lsb, 1'b1, 1'b0, 1'b0};
            obs = {env_q, bus.s, bus.I, bus.MSB_in, bus.LSB_in, bus.busy, bus.done, bus.cmd_ready};
            n_checks++;
            if (obs !== exp) $display("FAIL cmd op%0d cnt%0d cycle %0d: got %b expected %b", op, cnt, c, obs, exp);
            else n_pass++;
            case (op)
                2'b00:   qe = data;
                2'b10:   qe = {qe[2:0], b_lsb};
                default: qe = {b_msb, qe[3:1]};
            endcase
            if (churn) begin
                bus.cmd_op    = 2'($urandom);
                bus.cmd_count = 4'($urandom);
                bus.cmd_data  = 4'($urandom);
            end
            @(negedge clk);
        end
        exp = {qe, 2'b00, last_I, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        obs = {env_q, bus.s, bus.I, bus.MSB_in, bus.LSB_in, bus.busy, bus.done, bus.cmd_ready};
        n_checks++;
        if (obs !== exp) $display("FAIL done op%0d cnt%0d: got %b expected %b", op, cnt, obs, exp);
        else n_pass++;
        if (churn) bus.cmd_data = ~bus.cmd_data;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        exp = {qe, 2'b00, last_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        obs = {env_q, bus.s, bus.I, bus.MSB_in, bus.LSB_in, bus.busy, bus.done, bus.cmd_ready};
        n_checks++;
        if (obs !== exp) $display("FAIL idle_return op%0d cnt%0d: got %b expected %b", op, cnt, obs, exp);
        else n_pass++;
    endtask

    task automatic test_load();
        run_cmd(2'b00, 0, 4'b1011, 1'b0);
        n_checks++;
        if (env_q !== 4'b1011) $display("FAIL load_q: got %b expected 1011", env_q);
        else n_pass++;
    endtask

    task automatic test_shr();
        run_cmd(2'b00, 0, 4'b0000, 1'b0);
        run_cmd(2'b01, 4, 4'b0110, 1'b0);
        n_checks++;
        if (env_q !== 4'b0110) $display("FAIL shr_final_q: got %b expected 0110", env_q);
        else n_pass++;
    endtask

    task automatic test_shl();
        run_cmd(2'b00, 0, 4'b0000, 1'b0);
        run_cmd(2'b10, 6, 4'b1001, 1'b0);
        n_checks++;
        if (env_q !== 4'b0100) $display("FAIL shl_final_q: got %b expected 0100", env_q);
        else n_pass++;
        run_cmd(2'b01, 0, 4'b1111, 1'b0);
    endtask

    task automatic test_ror();
        run_cmd(2'b00, 0, 4'b0001, 1'b0);
        run_cmd(2'b11, 5, 4'b1110, 1'b0);
        n_checks++;
        if (env_q !== 4'b1000) $display("FAIL ror_final_q: got %b expected 1000", env_q);
        else n_pass++;
    endtask

    task automatic test_wrap();
        run_cmd(2'b01, 15, 4'b1101, 1'b0);
        run_cmd(2'b10, 15, 4'b0111, 1'b1);
    endtask

    task automatic test_abort();
        logic [10:0] obs;
        int          done_seen;
        int          waited;
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_count = 4'd15;
        bus.cmd_data  = 4'b1111;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (bus.s !== 2'b01 || bus.busy !== 1'b1) $display("FAIL abort_start: got s=%b busy=%b expected s=01 busy=1", bus.s, bus.busy);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        obs = {bus.s, bus.I, bus.MSB_in, bus.LSB_in, bus.busy, bus.done, bus.cmd_ready};
        n_checks++;
        if (obs !== 11'b0) $display("FAIL abort_reset: got %b expected %b", obs, 11'b0);
        else n_pass++;
        reset  = 1'b0;
        last_I = 4'b0000;
        done_seen = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.s !== 2'b00) done_seen++;
        end
        n_checks++;
        if (done_seen != 0 || bus.cmd_ready !== 1'b1)
            $display("FAIL abort_no_done: got %0d active cycles ready=%b expected 0 active ready=1", done_seen, bus.cmd_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_cmd(2'b01, 7, 4'b1010, 1'b1);
        run_cmd(2'b00, 0, 4'b0110, 1'b1);
        run_cmd(2'b11, 6, 4'b0000, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 4'($urandom), 1'($urandom));
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_shr();
        test_shl();
        test_ror();
        test_wrap();
        test_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
